// File: rtl/pwm399_pkg.sv
// Shared types and register map for the fractional PWM generator.
package pwm399_pkg;

    localparam int unsigned COARSE_W  = 15;
    localparam int unsigned FRAC_BITS = 3;
    localparam int unsigned TARGET_W  = COARSE_W + FRAC_BITS + 1;

    localparam logic [1:0] REG_B0     = 2'd0;
    localparam logic [1:0] REG_B1     = 2'd1;
    localparam logic [1:0] REG_B2     = 2'd2;
    localparam logic [1:0] REG_COMMIT = 2'd3;

    typedef struct packed {
        logic [COARSE_W-1:0]  coarse;
        logic [FRAC_BITS-1:0] frac;
        logic                 inv;
    } pwm_target_t;

endpackage

// File: rtl/pwm_deadband.sv
// Splits a PWM level into two non-overlapping outputs separated by DEADTIME low clocks.
module pwm_deadband #(
    parameter int unsigned DEADTIME = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic pwm_hi_o,
    output logic pwm_lo_o
);

    localparam int unsigned DtW = $clog2(DEADTIME + 1);
    localparam logic [DtW-1:0] DtMax = DtW'(DEADTIME);

    logic           level_q;
    logic [DtW-1:0] dt_cnt_q, dt_cnt_d;
    logic           pwm_hi_q, pwm_lo_q;
    logic           settled;

    // Any level change restarts the dead band; both outputs stay low until it expires.
    always_comb begin
        dt_cnt_d = dt_cnt_q;
        if (level_i != level_q) begin
            dt_cnt_d = '0;
        end else if (dt_cnt_q != DtMax) begin
            dt_cnt_d = dt_cnt_q + DtW'(1);
        end
        settled = (dt_cnt_d == DtMax);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q  <= 1'b0;
            dt_cnt_q <= '0;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else begin
            level_q  <= level_i;
            dt_cnt_q <= dt_cnt_d;
            pwm_hi_q <= level_i & settled;
            pwm_lo_q <= ~level_i & settled;
        end
    end

    assign pwm_hi_o = pwm_hi_q;
    assign pwm_lo_o = pwm_lo_q;

endmodule

// File: rtl/pwm_frac_gen.sv
// Double-buffered PWM with 1/8-LSB sigma-delta duty dithering.
// Optional dead-band outputs when PWM_DEADTIME_EN is defined.
module pwm_frac_gen
    import pwm399_pkg::*;
#(
    parameter int unsigned CNT_W    = 15,
    parameter int unsigned FRAC_W   = 3,
    parameter int unsigned DEADTIME = 4
) (
    input  logic       clk_USB,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       pwm0,
    output logic       pwm1,
    output logic       period_stb,
    output logic       commit_pend
);

    localparam int unsigned HiW = COARSE_W + 1;

    if (CNT_W > COARSE_W || FRAC_W != FRAC_BITS || DEADTIME >= (1 << CNT_W)) begin : g_bad_cfg
        $error("pwm_frac_gen: unsupported CNT_W/FRAC_W/DEADTIME combination");
    end

    logic [CNT_W-1:0]    cnt_q;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic [TARGET_W-1:0] shadow_q, shadow_d;
    pwm_target_t         active_q, active_d, shadow_t;
    logic                commit_pend_q, commit_pend_d;
    logic                period_stb_q;

    logic                wrap, apply, commit_wr;
    logic [FRAC_W:0]     acc_sum;
    logic [HiW-1:0]      hi;
    logic                level;

    assign shadow_t  = pwm_target_t'(shadow_q);
    assign wrap      = (cnt_q == {CNT_W{1'b1}});
    assign commit_wr = wr_en && (wr_addr == REG_COMMIT);
    assign apply     = wrap && commit_pend_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            case (wr_addr)
                REG_B0:  shadow_d[7:0]   = wr_data;
                REG_B1:  shadow_d[15:8]  = wr_data;
                REG_B2:  shadow_d[18:16] = wr_data[2:0];
                default: shadow_d        = shadow_q;
            endcase
        end
    end

    // A commit write landing on the wrap itself is only seen at the following wrap.
    always_comb begin
        commit_pend_d = (commit_pend_q && !wrap) || commit_wr;
        active_d      = apply ? shadow_t : active_q;
        acc_sum       = apply ? {1'b0, shadow_t.frac}
                              : {1'b0, acc_q} + {1'b0, active_q.frac};
        acc_d         = acc_q;
        carry_d       = carry_q;
        if (wrap) begin
            {carry_d, acc_d} = acc_sum;
        end
    end

    // Wide compare so hi == 2^CNT_W (or any larger coarse) yields a constant high.
    assign hi    = {1'b0, active_q.coarse} + {{COARSE_W{1'b0}}, carry_q};
    assign level = (HiW'(cnt_q) < hi) ^ active_q.inv;

    always_ff @(posedge clk_USB) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            carry_q       <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            commit_pend_q <= 1'b0;
            period_stb_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_q + CNT_W'(1);
            acc_q         <= acc_d;
            carry_q       <= carry_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_pend_q <= commit_pend_d;
            period_stb_q  <= wrap;
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadband #(
        .DEADTIME (DEADTIME)
    ) u_deadband (
        .clk_i    (clk_USB),
        .rst_ni   (rst_n),
        .level_i  (level),
        .pwm_hi_o (pwm0),
        .pwm_lo_o (pwm1)
    );
`else
    logic pwm0_q, pwm1_q;

    always_ff @(posedge clk_USB) begin
        if (!rst_n) begin
            pwm0_q <= 1'b0;
            pwm1_q <= 1'b1;
        end else begin
            pwm0_q <= level;
            pwm1_q <= ~level;
        end
    end

    assign pwm0 = pwm0_q;
    assign pwm1 = pwm1_q;
`endif

    assign period_stb  = period_stb_q;
    assign commit_pend = commit_pend_q;

endmodule

// File: tb/tb_pwm_frac_gen.sv
// Randomized self-checking bench for pwm_frac_gen against a per-period duty model.
module tb_pwm_frac_gen;

    localparam int CNT_W = 9;
    localparam int P     = 1 << CNT_W;

    logic       clk_USB = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       pwm0, pwm1, period_stb, commit_pend;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_frac_gen #(
        .CNT_W (CNT_W)
    ) dut (
        .clk_USB     (clk_USB),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm0        (pwm0),
        .pwm1        (pwm1),
        .period_stb  (period_stb),
        .commit_pend (commit_pend)
    );

    always #5 clk_USB = ~clk_USB;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Caller sits at a negedge; the write is captured on the following posedge.
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk_USB);
        wr_en = 1'b0;
    endtask

    task automatic wait_stb();
        bit seen = 0;
        for (int i = 0; i < 2 * P + 2 && !seen; i++) begin
            @(negedge clk_USB);
            if (period_stb) seen = 1;
        end
        if (!seen) check("stb_timeout", 0, 1);
    endtask

    // Ends on the negedge where period_stb announces the new target.
    task automatic commit(input int coarse, input int frac, input int inv, input bit bytes);
        wait_stb();
        repeat ($urandom_range(1, P / 2)) @(negedge clk_USB);
        if (bytes) begin
            wr(2'd0, 8'(((coarse & 15) << 4) | ((frac & 7) << 1) | (inv & 1)));
            wr(2'd1, 8'((coarse >> 4) & 255));
            wr(2'd2, 8'((coarse >> 12) & 7));
        end
        wr(2'd3, 8'($urandom));
        check("pend_set", int'(commit_pend), 1);
        wait_stb();
        check("pend_clr", int'(commit_pend), 0);
    endtask

    // Model: period k after a commit has high time coarse + (floor(k*f/8) - floor((k-1)*f/8)).
    task automatic measure(input int coarse, input int frac, input int inv, input int k0,
                           input int nper, input bit pend_hold);
        for (int p = 0; p < nper; p++) begin
            int k = k0 + p;
            int hi = coarse + ((k * frac) >> 3) - (((k - 1) * frac) >> 3);
            int werr = 0, cerr = 0, perr = 0, serr = 0;
            for (int j = 1; j <= P; j++) begin
                logic e;
                @(negedge clk_USB);
                e = logic'((j - 1) < hi) ^ logic'(inv & 1);
                if (pwm0 !== e) werr++;
                if (pwm1 !== ~pwm0) cerr++;
                if (j < P && pend_hold && commit_pend !== 1'b1) perr++;
                if (j < P && period_stb !== 1'b0) serr++;
            end
            check($sformatf("wave c=%0d f=%0d i=%0d k=%0d", coarse, frac, inv, k), werr, 0);
            check("pwm1_compl", cerr, 0);
            if (pend_hold) check("pend_hold", perr, 0);
            check("stb_quiet", serr, 0);
            check("stb_end", int'(period_stb), 1);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk_USB);
        check("rst_pwm0", int'(pwm0), 0);
        check("rst_pwm1", int'(pwm1), 1);
        check("rst_pend", int'(commit_pend), 0);
        check("rst_stb", int'(period_stb), 0);

        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk_USB);
            n++;
            if (period_stb) break;
        end
        check("first_stb", n, P);

        // Dither pattern 308,308,308,309 repeating.
        commit(308, 2, 0, 1);
        measure(308, 2, 0, 1, 8, 0);

        // Full-scale: 7 of 8 periods at 100 percent, one at P-1.
        commit(P - 1, 7, 0, 1);
        measure(P - 1, 7, 0, 1, 8, 0);

        // Commit write on the wrap cycle is deferred by one period.
        commit(100, 0, 0, 1);
        measure(100, 0, 0, 1, 1, 0);
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h10);
        wr(2'd2, 8'h00);
        repeat (P - 4) @(negedge clk_USB);
        wr(2'd3, 8'h00);
        check("defer_stb", int'(period_stb), 1);
        check("defer_pend", int'(commit_pend), 1);
        measure(100, 0, 0, 1, 1, 1);
        check("defer_clr", int'(commit_pend), 0);
        measure(256, 0, 1, 1, 2, 0);

        for (int r = 0; r < 4; r++) begin
            int c, f, iv, sel;
            sel = $urandom_range(0, 5);
            c = (sel == 0) ? P : (sel == 1) ? $urandom_range(P, 32767) :
                (sel == 2) ? 0 : $urandom_range(0, P - 1);
            f = $urandom_range(0, 7);
            iv = $urandom_range(0, 1);
            commit(c, f, iv, 1);
            measure(c, f, iv, 1, 8, 0);
        end

        // Mid-period reset clears active and shadow.
        commit(200, 3, 0, 1);
        repeat (P / 3) @(negedge clk_USB);
        rst_n = 1'b0;
        @(negedge clk_USB);
        rst_n = 1'b1;
        check("mrst_pwm0", int'(pwm0), 0);
        check("mrst_pwm1", int'(pwm1), 1);
        check("mrst_pend", int'(commit_pend), 0);
        wait_stb();
        measure(0, 0, 0, 1, 1, 0);
        commit(0, 0, 0, 0);
        measure(0, 0, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
